// File: rtl/cycle_snapshot_pkg.sv
// cycle_snapshot_pkg: readout beat states and beat count shared by the snapshot reader and its bench
package cycle_snapshot_pkg;
    typedef enum logic [1:0] {IDLE, MASK, LO, HI} beat_e;
    localparam int unsigned BeatCount = 3;
endpackage

// File: rtl/fifo_v3.sv
// fifo_v3: synchronous FIFO, power-of-two DEPTH, push accepted while full if a pop happens in the same cycle
// Ports: clk_i/rst_ni clock and async active-low reset; flush_i empties the FIFO;
//        data_i/push_i write side; data_o/pop_i head and pop; full_o/empty_o/usage_o status
//        (usage_o wraps to 0 when full, so {full_o, usage_o} is the occupancy)
module fifo_v3 #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ADDR_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_DEPTH-1:0] rptr, wptr;
    logic [ADDR_DEPTH:0]   cnt;
    logic                  do_pop, do_push;

    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign do_push = push_i && !flush_i && (!full_o || do_pop);
    assign full_o  = cnt == (ADDR_DEPTH+1)'(DEPTH);
    assign empty_o = cnt == '0;
    assign usage_o = cnt[ADDR_DEPTH-1:0];
    assign data_o  = mem[rptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni || flush_i) begin
            rptr <= '0;
            wptr <= '0;
            cnt  <= '0;
        end else begin
            rptr <= rptr + ADDR_DEPTH'(do_pop);
            wptr <= wptr + ADDR_DEPTH'(do_push);
            cnt  <= cnt + (ADDR_DEPTH+1)'(do_push) - (ADDR_DEPTH+1)'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wptr] <= data_i;
    end
endmodule

// File: rtl/cycle_snapshot_reader.sv
// cycle_snapshot_reader: timestamps event strobes into a FIFO and reads each entry out as MASK/LO/HI beats
// Ports: clk_i/rst_ni clock and async active-low reset; cycles_i 64-bit cycle count; event_i strobes;
//        clear_i synchronous flush; rd_valid_o/rd_ready_i/rd_data_o/rd_last_o read beat stream;
//        overflow_o sticky drop flag; drop_cnt_o saturating drop count; fill_o FIFO occupancy
module cycle_snapshot_reader
    import cycle_snapshot_pkg::*;
#(
    parameter int unsigned NumEvents = 4,
    parameter int unsigned Depth     = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [63:0]            cycles_i,
    input  logic [NumEvents-1:0]   event_i,
    input  logic                   clear_i,
    output logic                   rd_valid_o,
    input  logic                   rd_ready_i,
    output logic [31:0]            rd_data_o,
    output logic                   rd_last_o,
    output logic                   overflow_o,
    output logic [15:0]            drop_cnt_o,
    output logic [$clog2(Depth):0] fill_o
);
    localparam int unsigned Aw    = $clog2(Depth);
    localparam int unsigned FillW = Aw + 1;
    localparam int unsigned Ew    = NumEvents + 64;

    beat_e           state, nxt;
    logic            full, empty, hs, pop, push, drop, more;
    logic [Aw-1:0]   usage;
    logic [Ew-1:0]   head;

    assign hs     = rd_valid_o && rd_ready_i;
    assign pop    = hs && state == HI;
    assign push   = |event_i && !clear_i;
    assign drop   = push && full && !pop;
    assign fill_o = {full, usage};
    // the FIFO is non-empty in HI, so any fill other than 1 means another entry stays behind
    assign more   = push || (fill_o != FillW'(1));

    fifo_v3 #(.DATA_WIDTH(Ew), .DEPTH(Depth)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (clear_i),
        .full_o  (full),
        .empty_o (empty),
        .usage_o (usage),
        .data_i  ({event_i, cycles_i}),
        .push_i  (push),
        .data_o  (head),
        .pop_i   (pop)
    );

    // IDLE jumps to MASK on the capturing edge itself, giving one cycle from capture to rd_valid_o
    always_comb begin
        nxt = clear_i        ? IDLE :
              state == IDLE  ? ((!empty || push) ? MASK : IDLE) :
              !hs            ? state :
              state == MASK  ? LO :
              state == LO    ? HI :
              more           ? MASK : IDLE;
    end

    // the head entry only moves on the HI pop, so decoding the beat from the stored entry is stall-stable
    always_comb begin
        rd_data_o = state == MASK ? 32'(head[Ew-1:64]) :
                    state == LO   ? head[31:0] :
                    state == HI   ? head[63:32] : 32'h0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            rd_valid_o <= 1'b0;
            rd_last_o  <= 1'b0;
        end else begin
            state      <= nxt;
            rd_valid_o <= nxt != IDLE;
            rd_last_o  <= nxt == HI;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni || clear_i) begin
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end else if (drop) begin
            overflow_o <= 1'b1;
            drop_cnt_o <= drop_cnt_o + 16'(drop_cnt_o != 16'hFFFF);
        end
    end
endmodule

// File: tb/tb_cycle_snapshot_reader.sv
// tb_cycle_snapshot_reader: random and directed stimulus checked against a queue-based snapshot model
module tb_cycle_snapshot_reader;
    import cycle_snapshot_pkg::*;

    localparam int Depth = 8;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [63:0] cycles_i = '0;
    logic [3:0]  event_i = '0;
    logic        clear_i = 1'b0;
    logic        rd_valid_o;
    logic        rd_ready_i = 1'b0;
    logic [31:0] rd_data_o;
    logic        rd_last_o;
    logic        overflow_o;
    logic [15:0] drop_cnt_o;
    logic [3:0]  fill_o;

    cycle_snapshot_reader #(.NumEvents(4), .Depth(Depth)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .cycles_i   (cycles_i),
        .event_i    (event_i),
        .clear_i    (clear_i),
        .rd_valid_o (rd_valid_o),
        .rd_ready_i (rd_ready_i),
        .rd_data_o  (rd_data_o),
        .rd_last_o  (rd_last_o),
        .overflow_o (overflow_o),
        .drop_cnt_o (drop_cnt_o),
        .fill_o     (fill_o)
    );

    always #5 clk_i = ~clk_i;

    int          tests = 0;
    int          fails = 0;
    logic [67:0] q[$];
    int          bi = 0;
    int          mdrop = 0;
    bit          movf = 1'b0;
    logic [63:0] cyc = 64'hFFFF_FFFF_FFFF_FFF8;
    int          peak = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] beat(input logic [67:0] e, input int b);
        return b == 0 ? {28'h0, e[67:64]} : b == 1 ? e[31:0] : e[63:32];
    endfunction

    task automatic model_reset();
        q.delete();
        bi = 0;
        mdrop = 0;
        movf = 1'b0;
    endtask

    task automatic step(input logic [3:0] ev, input logic rdy, input logic clr);
        bit popped;
        @(negedge clk_i);
        check("valid", rd_valid_o, q.size() != 0);
        check("fill", fill_o, q.size());
        check("drop", drop_cnt_o, mdrop);
        check("ovf", overflow_o, movf);
        if (q.size() != 0) begin
            check("data", rd_data_o, beat(q[0], bi));
            check("last", rd_last_o, bi == BeatCount - 1);
        end
        if (int'(fill_o) > peak) peak = int'(fill_o);
        event_i    = ev;
        rd_ready_i = rdy;
        clear_i    = clr;
        cycles_i   = cyc;
        if (clr) model_reset();
        else begin
            popped = 1'b0;
            if (q.size() != 0 && rdy) begin
                bi++;
                if (bi == BeatCount) begin
                    bi = 0;
                    popped = 1'b1;
                end
            end
            if (ev != 0) begin
                if (q.size() - int'(popped) < Depth) q.push_back({ev, cyc});
                else begin
                    movf = 1'b1;
                    if (mdrop != 16'hFFFF) mdrop++;
                end
            end
            if (popped) void'(q.pop_front());
        end
        cyc++;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(4'h0, 1'b1, 1'b0);
    endtask

    task automatic advance_to(input int target);
        for (int i = 0; i < 12 && !(q.size() != 0 && bi == target); i++) step(4'h0, 1'b1, 1'b0);
        check("reach_beat", bi, target);
    endtask

    initial begin
        repeat (2) @(negedge clk_i);
        check("rst_valid", rd_valid_o, 0);
        check("rst_last", rd_last_o, 0);
        check("rst_data", rd_data_o, 0);
        check("rst_fill", fill_o, 0);
        check("rst_drop", drop_cnt_o, 0);
        check("rst_ovf", overflow_o, 0);
        rst_ni = 1'b1;

        cyc = 64'h0000_0001_0000_0005;
        step(4'b0010, 1'b1, 1'b0);
        step(4'h0, 1'b1, 1'b0);
        check("lat_valid", rd_valid_o, 1);
        check("mask_beat", rd_data_o, 32'h2);
        drain(4);

        peak = 0;
        step(4'b1001, 1'b1, 1'b0);
        step(4'h0, 1'b1, 1'b0);
        check("mask9", rd_data_o, 32'h9);
        drain(4);
        check("peak1", peak, 1);

        for (int i = 0; i < 10; i++) step(4'($urandom_range(1, 15)), 1'b0, 1'b0);
        step(4'h0, 1'b0, 1'b0);
        check("ovf_fill", fill_o, 8);
        check("ovf_drop", drop_cnt_o, 2);
        check("ovf_flag", overflow_o, 1);
        drain(28);

        step(4'h0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(4'h4, 1'b0, 1'b0);
        advance_to(2);
        step(4'h8, 1'b1, 1'b0);
        step(4'h0, 1'b0, 1'b0);
        check("hi_push_fill", fill_o, 8);
        check("hi_push_drop", drop_cnt_o, 0);
        drain(30);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) cyc = {$urandom, $urandom};
            step($urandom_range(0, 2) == 0 ? 4'($urandom) : 4'h0, 1'($urandom), 1'b0);
        end
        drain(30);

        for (int i = 0; i < 10; i++) step(4'h1, 1'b0, 1'b0);
        advance_to(1);
        step(4'h3, 1'($urandom), 1'b1);
        step(4'h0, 1'b0, 1'b0);
        check("clr_fill", fill_o, 0);
        check("clr_valid", rd_valid_o, 0);
        check("clr_ovf", overflow_o, 0);
        check("clr_drop", drop_cnt_o, 0);

        for (int i = 0; i < 10; i++) step(4'h2, 1'b0, 1'b0);
        advance_to(2);
        step(4'h0, 1'b0, 1'b0);
        #2 rst_ni = 1'b0;
        #1;
        check("arst_valid", rd_valid_o, 0);
        check("arst_last", rd_last_o, 0);
        check("arst_data", rd_data_o, 0);
        check("arst_fill", fill_o, 0);
        check("arst_drop", drop_cnt_o, 0);
        check("arst_ovf", overflow_o, 0);
        model_reset();
        event_i = 4'h0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        step(4'h5, 1'b1, 1'b0);
        step(4'h0, 1'b1, 1'b0);
        check("post_rst_mask", rd_data_o, 32'h5);
        drain(4);

        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 1) == 0 ? 4'($urandom) : 4'h0, 1'($urandom), $urandom_range(0, 59) == 0);
        drain(30);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
